// File: rtl/ipline_pkg.sv
// Shared definitions for the instruction-line sequencer: opcode bit map,
// data-line command encoding and sequencer state encoding.
package ipline_pkg;

  localparam int OP_NOP   = 0;
  localparam int OP_HALT  = 1;
  localparam int OP_INC   = 2;
  localparam int OP_DEC   = 3;
  localparam int OP_APINC = 4;
  localparam int OP_LOOPB = 5;
  localparam int OP_LOOPE = 6;
  localparam int OP_APDEC = 7;
  localparam int OP_OUT   = 8;
  localparam int OP_IN    = 9;
  localparam int OP_USED  = 10;

  typedef enum logic [1:0] {
    CMD_DATA_INC = 2'd0,
    CMD_DATA_DEC = 2'd1,
    CMD_AP_INC   = 2'd2,
    CMD_AP_DEC   = 2'd3
  } data_cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_OP,
    S_EXEC_DATA,
    S_EXEC_IO,
    S_ACK,
    S_HALTED,
    S_FAULT
  } seq_state_e;

  // Only meaningful for a one-hot data opcode.
  function automatic data_cmd_e cmd_of(input logic [OP_USED-1:0] op);
    data_cmd_e c;
    c = CMD_AP_DEC;
    if (op[OP_INC])        c = CMD_DATA_INC;
    else if (op[OP_DEC])   c = CMD_DATA_DEC;
    else if (op[OP_APINC]) c = CMD_AP_INC;
    return c;
  endfunction

endpackage

// File: rtl/ipline_sequencer_watchdog.sv
// Watchdog for data-line / IO transactions: counts cycles while enabled,
// saturates at all-ones and flags expiry there.
module seq_watchdog #(
  parameter int WDOG_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [WDOG_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr)
      count <= '0;
    else if (en && !expired)
      count <= count + WDOG_W'(1);
  end

  assign expired = &count;

endmodule

// File: rtl/ipline_sequencer.sv
// Execution controller: takes one-hot opcodes from the instruction line,
// dispatches them to the data line or IO, and acknowledges each one.
module ipline_sequencer
  import ipline_pkg::*;
#(
  parameter int OPCODE_W = 16,
  parameter int CNT_W    = 24,
  parameter int WDOG_W   = 8
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Run,
  input  logic                Step,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                OpcodeReady,
  output logic                OpcodeAck,
  output logic [1:0]          DataCmd,
  output logic                DataReq,
  input  logic                DataReady,
  output logic                OutReq,
  input  logic                OutAck,
  output logic                InReq,
  input  logic                InAck,
  output logic                Halted,
  output logic                Fault,
  output logic                Busy,
  output logic [CNT_W-1:0]    InsnCount
);

  seq_state_e state;
  logic       step_pend;
  logic       halt_pend;
  logic       in_exec;
  logic       wd_expired;
  logic       is_flow;
  logic       is_data;

  assign in_exec = (state == S_EXEC_DATA) || (state == S_EXEC_IO);
  assign is_flow = Opcode[OP_NOP] | Opcode[OP_LOOPB] | Opcode[OP_LOOPE];
  assign is_data = Opcode[OP_INC] | Opcode[OP_DEC] | Opcode[OP_APINC] | Opcode[OP_APDEC];

  seq_watchdog #(.WDOG_W(WDOG_W)) u_wdog (
    .clk     (Clk),
    .rst     (Rst),
    .clr     (!in_exec),
    .en      (in_exec),
    .expired (wd_expired)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= S_IDLE;
      step_pend <= 1'b0;
      halt_pend <= 1'b0;
      OpcodeAck <= 1'b0;
      DataCmd   <= CMD_DATA_INC;
      DataReq   <= 1'b0;
      OutReq    <= 1'b0;
      InReq     <= 1'b0;
      InsnCount <= '0;
    end else begin
      OpcodeAck <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (Run) begin
            state <= S_WAIT_OP;
          end else if (Step) begin
            step_pend <= 1'b1;
            state     <= S_WAIT_OP;
          end
        end

        S_WAIT_OP: begin
          if (!Run && !step_pend) begin
            state <= S_IDLE;
          // During the Ack cycle the instruction line still shows the
          // opcode just retired, so it must not be decoded again.
          end else if (OpcodeReady && !OpcodeAck) begin
            if (!$onehot(Opcode)) begin
              state <= S_FAULT;
            end else if (is_flow) begin
              state <= S_ACK;
            end else if (Opcode[OP_HALT]) begin
              halt_pend <= 1'b1;
              state     <= S_ACK;
            end else if (is_data) begin
              DataReq <= 1'b1;
              DataCmd <= cmd_of(Opcode[OP_USED-1:0]);
              state   <= S_EXEC_DATA;
            end else if (Opcode[OP_OUT]) begin
              OutReq <= 1'b1;
              state  <= S_EXEC_IO;
            end else if (Opcode[OP_IN]) begin
              InReq <= 1'b1;
              state <= S_EXEC_IO;
            end else begin
              state <= S_FAULT;
            end
          end
        end

        S_EXEC_DATA: begin
          if (DataReady) begin
            DataReq <= 1'b0;
            state   <= S_ACK;
          end else if (wd_expired) begin
            DataReq <= 1'b0;
            state   <= S_FAULT;
          end
        end

        S_EXEC_IO: begin
          if ((OutReq && OutAck) || (InReq && InAck)) begin
            OutReq <= 1'b0;
            InReq  <= 1'b0;
            state  <= S_ACK;
          end else if (wd_expired) begin
            OutReq <= 1'b0;
            InReq  <= 1'b0;
            state  <= S_FAULT;
          end
        end

        S_ACK: begin
          OpcodeAck <= 1'b1;
          InsnCount <= InsnCount + CNT_W'(1);
          step_pend <= 1'b0;
          if (halt_pend)
            state <= S_HALTED;
          else if (Run)
            state <= S_WAIT_OP;
          else
            state <= S_IDLE;
        end

        S_HALTED, S_FAULT: begin
          DataReq <= 1'b0;
          OutReq  <= 1'b0;
          InReq   <= 1'b0;
        end

        default: state <= S_FAULT;
      endcase
    end
  end

  assign Halted = (state == S_HALTED);
  assign Fault  = (state == S_FAULT);
  assign Busy   = (state != S_IDLE) && (state != S_HALTED);

endmodule
